l1_miss_tracker: RTL and testbench
==================================

L1_MISS_TRACKER -- requirements
Module: l1_miss_tracker

Interface
REQ-001 SHALL have parameter NUM_ENTRIES, default 8: number of outstanding line misses (power of two, 2..32).
REQ-002 SHALL have parameter NUM_STRANDS, default 4: strands per core sharing this tracker.
REQ-003 SHALL have parameter ADDR_WIDTH, default 26: line address width.
REQ-004 SHALL have parameter WAY_WIDTH, default 2: L1 way index width.
REQ-005 SHALL have ports, in this order:
- clk  in  1  sole clock.
- reset_n  in  1  asynchronous, active-low reset.
- request_i  in  1  miss/sync-load request this cycle.
- request_addr  in  ADDR_WIDTH  line address.
- strand_i  in  clog2(NUM_STRANDS)  requesting strand.
- synchronized_i  in  1  synchronized (atomic) load.
- victim_way_i  in  WAY_WIDTH  suggested fill way.
- accept_o  out  1  combinational; request recorded this cycle.
- collision_o  out  1  combinational; request matches a line completing this cycle.
- l2req_valid_o  out  1  L2 request valid.
- l2req_ready_i  in  1  L2 accepts request.
- l2req_addr_o  out  ADDR_WIDTH  request line address.
- l2req_way_o  out  WAY_WIDTH  fill way.
- l2req_sync_o  out  1  synchronized flag.
- l2req_entry_o  out  clog2(NUM_ENTRIES)  tag returned with the response.
- l2rsp_valid_i  in  1  response for this unit/core (already filtered).
- l2rsp_entry_i  in  clog2(NUM_ENTRIES)  completing entry.
- load_complete_strands_o  out  NUM_STRANDS  one-cycle wake pulse per strand.
- occupancy_o  out  clog2(NUM_ENTRIES)+1  non-IDLE entries.

Function
REQ-006 Each entry SHALL hold state IDLE / WAIT_ISSUE / WAIT_RESPONSE, addr, way, sync flag and a strand wait mask.
REQ-007 A non-sync request whose addr equals a non-sync WAIT_ISSUE/WAIT_RESPONSE entry SHALL merge: set strand bit, accept_o=1, no new entry, no new L2 request.
REQ-008 Sync requests SHALL never merge and never be merged into.
REQ-009 A non-merging request SHALL allocate the lowest-index IDLE entry, state WAIT_ISSUE, accept_o=1.
REQ-010 With no IDLE entry and no merge, accept_o SHALL be 0 and nothing SHALL be recorded; the requester retries.
REQ-011 If request_addr equals the addr of the entry named by a valid l2rsp this cycle, collision_o SHALL be 1, accept_o 0, nothing recorded.
REQ-012 Allocation SHALL use registered state only: an entry freed by a response is not reusable until the next cycle.
REQ-013 Issue SHALL pick among WAIT_ISSUE entries round-robin, starting after the last issued index.
REQ-014 Once asserted, l2req_valid_o and all l2req payload SHALL stay stable until the cycle l2req_ready_i=1; the entry then moves to WAIT_RESPONSE.
REQ-015 Earliest l2req_valid_o SHALL be one cycle after acceptance.
REQ-016 On l2rsp_valid_i for an entry in WAIT_RESPONSE: next cycle, load_complete_strands_o SHALL equal that entry's mask for one cycle and the entry SHALL be IDLE.
REQ-017 A response naming an entry not in WAIT_RESPONSE SHALL be ignored and SHALL fire a simulation assertion.
REQ-018 A request from a strand already set in any wait mask SHALL fire an assertion.
REQ-019 occupancy_o SHALL be registered and track non-IDLE entry count exactly.

Reset
REQ-020 While reset_n=0: all entries IDLE, masks 0, round-robin pointer 0; l2req_valid_o, load_complete_strands_o and occupancy_o 0.
REQ-021 Reset mid-operation SHALL drop outstanding misses without wake pulses.
REQ-022 The first rising clk after reset_n deasserts SHALL accept requests normally.

Structure
REQ-023 Entry state enum and miss-entry struct SHALL live in the shared defines package.
REQ-024 Round-robin selection SHALL be a parametrised sub-module rr_arbiter (request vector in, one-hot grant out, update enable).

Verification
REQ-025 Strand 0 non-sync miss 0x100, ready=1 -> l2req addr 0x100 entry 0 next cycle; rsp entry 0 -> complete=0001 one cycle later, occupancy 0.
REQ-026 Strands 0,1,2 miss 0x200 on consecutive cycles -> one L2 request; rsp -> complete=0111 in a single pulse.
REQ-027 Sync load 0x300 strand 1 while non-sync 0x300 outstanding for strand 0 -> two entries, two L2 requests, separate wake pulses 0001 and 0010.
REQ-028 NUM_ENTRIES=8 filled with distinct addrs, ready=0 -> ninth distinct request accept_o=0; l2req payload stable across 10 stalled cycles.
REQ-029 Request 0x400 same cycle as rsp for entry holding 0x400 -> collision_o=1, accept_o=0, occupancy unchanged by request.
REQ-030 reset_n low with 3 entries outstanding -> occupancy 0, no complete pulse, later stale rsp ignored with assertion.

Source files
------------

// File: rtl/l1_miss_tracker_pkg.sv
// l1_miss_tracker_pkg: shared entry state and miss-entry record, sized for the widest supported configuration.
package l1_miss_tracker_pkg;
    localparam int MAX_ADDR_WIDTH = 64;
    localparam int MAX_WAY_WIDTH  = 8;
    localparam int MAX_STRANDS    = 32;
    typedef enum logic [1:0] {
        E_IDLE          = 2'd0,
        E_WAIT_ISSUE    = 2'd1,
        E_WAIT_RESPONSE = 2'd2
    } entry_state_e;
    typedef struct packed {
        entry_state_e              state;
        logic [MAX_ADDR_WIDTH-1:0] addr;
        logic [MAX_WAY_WIDTH-1:0]  way;
        logic                      sync;
        logic [MAX_STRANDS-1:0]    mask;
    } miss_entry_t;
endpackage

// File: rtl/l1_miss_tracker_rr_arbiter.sv
// rr_arbiter: one-hot round-robin arbiter; priority starts just after the last granted index.
module rr_arbiter #(
    parameter int N = 8,
    localparam int W = $clog2(N)
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic [N-1:0] req,
    input  logic         update,
    output logic [N-1:0] grant
);
    logic [W-1:0] ptr, idx, win;
    always_comb begin
        win = ptr;
        idx = ptr;
        grant = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + W'(k);
            if (req[idx]) win = idx;
        end
        grant[win] = |req;
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) ptr <= '0;
        else if (update && |req) ptr <= win + 1'b1;
    end
endmodule

// File: rtl/l1_miss_tracker.sv
// l1_miss_tracker: tracks outstanding L1 line misses, merges same-line loads across strands and issues to L2.
module l1_miss_tracker
    import l1_miss_tracker_pkg::*;
#(
    parameter int NUM_ENTRIES = 8,
    parameter int NUM_STRANDS = 4,
    parameter int ADDR_WIDTH  = 26,
    parameter int WAY_WIDTH   = 2,
    localparam int EW = $clog2(NUM_ENTRIES),
    localparam int SW = $clog2(NUM_STRANDS),
    localparam int OW = EW + 1
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   request_i,
    input  logic [ADDR_WIDTH-1:0]  request_addr,
    input  logic [SW-1:0]          strand_i,
    input  logic                   synchronized_i,
    input  logic [WAY_WIDTH-1:0]   victim_way_i,
    output logic                   accept_o,
    output logic                   collision_o,
    output logic                   l2req_valid_o,
    input  logic                   l2req_ready_i,
    output logic [ADDR_WIDTH-1:0]  l2req_addr_o,
    output logic [WAY_WIDTH-1:0]   l2req_way_o,
    output logic                   l2req_sync_o,
    output logic [EW-1:0]          l2req_entry_o,
    input  logic                   l2rsp_valid_i,
    input  logic [EW-1:0]          l2rsp_entry_i,
    output logic [NUM_STRANDS-1:0] load_complete_strands_o,
    output logic [OW-1:0]          occupancy_o
);
    miss_entry_t entries [NUM_ENTRIES];
    miss_entry_t rsp_entry, issue_entry;
    logic [NUM_ENTRIES-1:0] free_vec, merge_vec, wait_vec, grant;
    logic [EW-1:0] free_idx, merge_idx, grant_idx, issue_idx, lock_idx;
    logic [NUM_STRANDS-1:0] waiting;
    logic locked, rsp_hit, alloc;

    always_comb begin
        free_vec = '0;
        merge_vec = '0;
        wait_vec = '0;
        waiting = '0;
        free_idx = '0;
        merge_idx = '0;
        grant_idx = '0;
        for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
            free_vec[i] = entries[i].state == E_IDLE;
            wait_vec[i] = entries[i].state == E_WAIT_ISSUE;
            merge_vec[i] = !free_vec[i] && !entries[i].sync && !synchronized_i &&
                           entries[i].addr == MAX_ADDR_WIDTH'(request_addr);
            waiting = waiting | NUM_STRANDS'(entries[i].mask);
            if (free_vec[i]) free_idx = EW'(i);
            if (merge_vec[i]) merge_idx = EW'(i);
            if (grant[i]) grant_idx = EW'(i);
        end
    end

    assign rsp_entry = entries[l2rsp_entry_i];
    assign rsp_hit = l2rsp_valid_i && rsp_entry.state == E_WAIT_RESPONSE;
    assign collision_o = request_i && rsp_hit && rsp_entry.addr == MAX_ADDR_WIDTH'(request_addr);
    assign accept_o = request_i && !collision_o && (|merge_vec || |free_vec);
    assign alloc = accept_o && !(|merge_vec);

    // A presented request is locked to its entry until the L2 takes it, keeping the payload stable.
    assign issue_idx = locked ? lock_idx : grant_idx;
    assign issue_entry = entries[issue_idx];
    assign l2req_valid_o = locked || |wait_vec;
    assign l2req_addr_o = ADDR_WIDTH'(issue_entry.addr);
    assign l2req_way_o = WAY_WIDTH'(issue_entry.way);
    assign l2req_sync_o = issue_entry.sync;
    assign l2req_entry_o = issue_idx;

    rr_arbiter #(.N(NUM_ENTRIES)) u_arb (
        .clk    (clk),
        .reset_n(reset_n),
        .req    (wait_vec),
        .update (!locked),
        .grant  (grant)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_ENTRIES; i++) entries[i] <= '0;
            locked <= 1'b0;
            lock_idx <= '0;
            load_complete_strands_o <= '0;
            occupancy_o <= '0;
        end else begin
            load_complete_strands_o <= rsp_hit ? NUM_STRANDS'(rsp_entry.mask) : '0;
            occupancy_o <= occupancy_o + OW'(alloc) - OW'(rsp_hit);
            locked <= l2req_valid_o && !l2req_ready_i;
            lock_idx <= issue_idx;
            if (rsp_hit) begin
                entries[l2rsp_entry_i].state <= E_IDLE;
                entries[l2rsp_entry_i].mask <= '0;
            end
            if (l2req_valid_o && l2req_ready_i) entries[issue_idx].state <= E_WAIT_RESPONSE;
            if (alloc)
                entries[free_idx] <= '{state: E_WAIT_ISSUE,
                                       addr:  MAX_ADDR_WIDTH'(request_addr),
                                       way:   MAX_WAY_WIDTH'(victim_way_i),
                                       sync:  synchronized_i,
                                       mask:  MAX_STRANDS'(1) << strand_i};
            else if (accept_o)
                entries[merge_idx].mask <= entries[merge_idx].mask | (MAX_STRANDS'(1) << strand_i);
        end
    end

    rsp_targets_waiting_entry: assert property (@(posedge clk) disable iff (!reset_n)
        l2rsp_valid_i |-> rsp_hit);
    strand_not_already_waiting: assert property (@(posedge clk) disable iff (!reset_n)
        request_i |-> !waiting[strand_i]);
endmodule

// File: tb/tb_l1_miss_tracker.sv
// tb_l1_miss_tracker: directed scenarios plus randomized traffic checked against an abstract miss table.
module tb_l1_miss_tracker;
    logic        clk = 0;
    logic        reset_n = 0;
    logic        request_i = 0;
    logic [25:0] request_addr = 0;
    logic [3:0]  strand_i = 0;
    logic        synchronized_i = 0;
    logic [1:0]  victim_way_i = 0;
    logic        accept_o, collision_o, l2req_valid_o;
    logic        l2req_ready_i = 0;
    logic [25:0] l2req_addr_o;
    logic [1:0]  l2req_way_o;
    logic        l2req_sync_o;
    logic [2:0]  l2req_entry_o;
    logic        l2rsp_valid_i = 0;
    logic [2:0]  l2rsp_entry_i = 0;
    logic [15:0] load_complete_strands_o;
    logic [3:0]  occupancy_o;
    int checks = 0;
    int passes = 0;

    l1_miss_tracker #(.NUM_ENTRIES(8), .NUM_STRANDS(16), .ADDR_WIDTH(26), .WAY_WIDTH(2)) dut (
        .clk(clk), .reset_n(reset_n), .request_i(request_i), .request_addr(request_addr),
        .strand_i(strand_i), .synchronized_i(synchronized_i), .victim_way_i(victim_way_i),
        .accept_o(accept_o), .collision_o(collision_o), .l2req_valid_o(l2req_valid_o),
        .l2req_ready_i(l2req_ready_i), .l2req_addr_o(l2req_addr_o), .l2req_way_o(l2req_way_o),
        .l2req_sync_o(l2req_sync_o), .l2req_entry_o(l2req_entry_o), .l2rsp_valid_i(l2rsp_valid_i),
        .l2rsp_entry_i(l2rsp_entry_i), .load_complete_strands_o(load_complete_strands_o),
        .occupancy_o(occupancy_o)
    );

    always #5 clk = ~clk;

    task automatic drive(input int s, input logic [25:0] a, input logic sy, input logic [1:0] w);
        request_i = 1; strand_i = 4'(s); request_addr = a; synchronized_i = sy; victim_way_i = w;
    endtask

    task automatic test_reset();
        reset_n = 0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if (occupancy_o !== 4'd0) $display("FAIL reset_occ: got %0d expected 0", occupancy_o); else passes++;
        checks++; if (l2req_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", l2req_valid_o); else passes++;
        checks++; if (load_complete_strands_o !== 16'h0) $display("FAIL reset_complete: got %h expected 0", load_complete_strands_o); else passes++;
        reset_n = 1;
    endtask

    task automatic test_single();
        @(negedge clk); l2req_ready_i = 1; drive(0, 26'h100, 0, 2'd1); #1;
        checks++; if ({accept_o, collision_o} !== 2'b10) $display("FAIL single_accept: got %b expected 10", {accept_o, collision_o}); else passes++;
        @(negedge clk); request_i = 0; #1;
        checks++; if ({l2req_valid_o, l2req_addr_o, l2req_entry_o, l2req_way_o, l2req_sync_o} !== {1'b1, 26'h100, 3'd0, 2'd1, 1'b0})
            $display("FAIL single_l2req: got v%b a%h e%0d w%0d s%b expected v1 a100 e0 w1 s0", l2req_valid_o, l2req_addr_o, l2req_entry_o, l2req_way_o, l2req_sync_o); else passes++;
        checks++; if (occupancy_o !== 4'd1) $display("FAIL single_occ1: got %0d expected 1", occupancy_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 1; l2rsp_entry_i = 0; #1;
        checks++; if (l2req_valid_o !== 1'b0) $display("FAIL single_no_reissue: got %b expected 0", l2req_valid_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 0; #1;
        checks++; if (load_complete_strands_o !== 16'h0001) $display("FAIL single_complete: got %h expected 0001", load_complete_strands_o); else passes++;
        checks++; if (occupancy_o !== 4'd0) $display("FAIL single_occ0: got %0d expected 0", occupancy_o); else passes++;
        @(negedge clk); #1;
        checks++; if (load_complete_strands_o !== 16'h0) $display("FAIL single_pulse_len: got %h expected 0", load_complete_strands_o); else passes++;
    endtask

    task automatic test_merge();
        int hs = 0;
        logic [2:0] he = 0;
        l2req_ready_i = 1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); drive(s, 26'h200, 0, 2'd0); #1;
            checks++; if (accept_o !== 1'b1) $display("FAIL merge_accept%0d: got %b expected 1", s, accept_o); else passes++;
            if (l2req_valid_o && l2req_ready_i) begin hs++; he = l2req_entry_o; end
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk); request_i = 0; #1;
            if (l2req_valid_o && l2req_ready_i) hs++;
        end
        checks++; if (hs !== 1) $display("FAIL merge_l2_count: got %0d expected 1", hs); else passes++;
        checks++; if (he !== 3'd0) $display("FAIL merge_entry: got %0d expected 0", he); else passes++;
        checks++; if (occupancy_o !== 4'd1) $display("FAIL merge_occ: got %0d expected 1", occupancy_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 1; l2rsp_entry_i = he;
        @(negedge clk); l2rsp_valid_i = 0; #1;
        checks++; if (load_complete_strands_o !== 16'h0007) $display("FAIL merge_complete: got %h expected 0007", load_complete_strands_o); else passes++;
        checks++; if (occupancy_o !== 4'd0) $display("FAIL merge_occ0: got %0d expected 0", occupancy_o); else passes++;
    endtask

    task automatic test_sync();
        l2req_ready_i = 1;
        @(negedge clk); drive(0, 26'h300, 0, 2'd0); #1;
        checks++; if (accept_o !== 1'b1) $display("FAIL sync_accept_ns: got %b expected 1", accept_o); else passes++;
        @(negedge clk); drive(1, 26'h300, 1, 2'd3); #1;
        checks++; if (accept_o !== 1'b1) $display("FAIL sync_accept_s: got %b expected 1", accept_o); else passes++;
        checks++; if ({l2req_valid_o, l2req_entry_o, l2req_sync_o} !== {1'b1, 3'd0, 1'b0}) $display("FAIL sync_issue0: got v%b e%0d s%b expected v1 e0 s0", l2req_valid_o, l2req_entry_o, l2req_sync_o); else passes++;
        @(negedge clk); request_i = 0; #1;
        checks++; if ({l2req_valid_o, l2req_entry_o, l2req_sync_o, l2req_addr_o} !== {1'b1, 3'd1, 1'b1, 26'h300}) $display("FAIL sync_issue1: got v%b e%0d s%b a%h expected v1 e1 s1 a300", l2req_valid_o, l2req_entry_o, l2req_sync_o, l2req_addr_o); else passes++;
        @(negedge clk); #1;
        checks++; if ({l2req_valid_o, occupancy_o} !== {1'b0, 4'd2}) $display("FAIL sync_two_entries: got v%b occ%0d expected v0 occ2", l2req_valid_o, occupancy_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 1; l2rsp_entry_i = 0;
        @(negedge clk); l2rsp_entry_i = 1; #1;
        checks++; if (load_complete_strands_o !== 16'h0001) $display("FAIL sync_wake0: got %h expected 0001", load_complete_strands_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 0; #1;
        checks++; if (load_complete_strands_o !== 16'h0002) $display("FAIL sync_wake1: got %h expected 0002", load_complete_strands_o); else passes++;
        checks++; if (occupancy_o !== 4'd0) $display("FAIL sync_occ0: got %0d expected 0", occupancy_o); else passes++;
    endtask

    task automatic test_full_stall();
        logic [15:0] ew;
        l2req_ready_i = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk); drive(i, 26'h1000 + 26'(i), 0, 2'(i)); #1;
            checks++; if (accept_o !== 1'b1) $display("FAIL full_fill%0d: got %b expected 1", i, accept_o); else passes++;
        end
        @(negedge clk); drive(8, 26'h2000, 0, 2'd0); #1;
        checks++; if (accept_o !== 1'b0) $display("FAIL full_reject: got %b expected 0", accept_o); else passes++;
        checks++; if (occupancy_o !== 4'd8) $display("FAIL full_occ: got %0d expected 8", occupancy_o); else passes++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk); request_i = 0; #1;
            checks++; if ({l2req_valid_o, l2req_entry_o, l2req_addr_o, l2req_way_o, l2req_sync_o} !== {1'b1, 3'd0, 26'h1000, 2'd0, 1'b0})
                $display("FAIL full_stable%0d: got v%b e%0d a%h w%0d s%b expected v1 e0 a1000 w0 s0", k, l2req_valid_o, l2req_entry_o, l2req_addr_o, l2req_way_o, l2req_sync_o); else passes++;
        end
        for (int k = 0; k < 8; k++) begin
            @(negedge clk); l2req_ready_i = 1; #1;
            checks++; if ({l2req_valid_o, l2req_entry_o, l2req_addr_o} !== {1'b1, 3'(k), 26'h1000 + 26'(k)})
                $display("FAIL full_rr%0d: got v%b e%0d a%h expected v1 e%0d", k, l2req_valid_o, l2req_entry_o, l2req_addr_o, k); else passes++;
        end
        @(negedge clk); l2req_ready_i = 0; #1;
        checks++; if (l2req_valid_o !== 1'b0) $display("FAIL full_drained: got %b expected 0", l2req_valid_o); else passes++;
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk); l2rsp_valid_i = 1; l2rsp_entry_i = 3'(i); #1;
            ew = 16'd1 << (i + 1);
            if (i < 7) begin
                checks++; if (load_complete_strands_o !== ew) $display("FAIL full_wake%0d: got %h expected %h", i + 1, load_complete_strands_o, ew); else passes++;
            end
        end
        @(negedge clk); l2rsp_valid_i = 0; #1;
        checks++; if (load_complete_strands_o !== 16'h0001) $display("FAIL full_wake0: got %h expected 0001", load_complete_strands_o); else passes++;
        checks++; if (occupancy_o !== 4'd0) $display("FAIL full_occ0: got %0d expected 0", occupancy_o); else passes++;
    endtask

    task automatic test_collision();
        l2req_ready_i = 1;
        @(negedge clk); drive(0, 26'h400, 0, 2'd0); #1;
        checks++; if (accept_o !== 1'b1) $display("FAIL coll_first: got %b expected 1", accept_o); else passes++;
        @(negedge clk); request_i = 0; #1;
        checks++; if ({l2req_valid_o, l2req_entry_o} !== {1'b1, 3'd0}) $display("FAIL coll_issue: got v%b e%0d expected v1 e0", l2req_valid_o, l2req_entry_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 1; l2rsp_entry_i = 0; drive(1, 26'h400, 0, 2'd0); #1;
        checks++; if ({collision_o, accept_o} !== 2'b10) $display("FAIL coll_flags: got coll%b acc%b expected coll1 acc0", collision_o, accept_o); else passes++;
        checks++; if (occupancy_o !== 4'd1) $display("FAIL coll_occ1: got %0d expected 1", occupancy_o); else passes++;
        @(negedge clk); l2rsp_valid_i = 0; request_i = 0; #1;
        checks++; if ({occupancy_o, l2req_valid_o} !== {4'd0, 1'b0}) $display("FAIL coll_nothing_recorded: got occ%0d v%b expected occ0 v0", occupancy_o, l2req_valid_o); else passes++;
        checks++; if (load_complete_strands_o !== 16'h0001) $display("FAIL coll_wake: got %h expected 0001", load_complete_strands_o); else passes++;
    endtask

    task automatic test_reset_mid();
        l2req_ready_i = 1;
        for (int s = 0; s < 3; s++) begin
            @(negedge clk); drive(s, 26'h500 + 26'(s) * 26'h100, 0, 2'd0); #1;
            checks++; if (accept_o !== 1'b1) $display("FAIL rmid_accept%0d: got %b expected 1", s, accept_o); else passes++;
        end
        @(negedge clk); request_i = 0;
        @(negedge clk); #1;
        checks++; if ({occupancy_o, l2req_valid_o} !== {4'd3, 1'b0}) $display("FAIL rmid_outstanding: got occ%0d v%b expected occ3 v0", occupancy_o, l2req_valid_o); else passes++;
        reset_n = 0; #1;
        checks++; if ({occupancy_o, l2req_valid_o, load_complete_strands_o} !== {4'd0, 1'b0, 16'h0}) $display("FAIL rmid_cleared: got occ%0d v%b c%h expected all 0", occupancy_o, l2req_valid_o, load_complete_strands_o); else passes++;
        @(negedge clk); reset_n = 1; drive(3, 26'h800, 0, 2'd2); #1;
        checks++; if (accept_o !== 1'b1) $display("FAIL rmid_first_edge: got %b expected 1", accept_o); else passes++;
        @(negedge clk); request_i = 0; #1;
        checks++; if ({l2req_valid_o, l2req_entry_o, l2req_addr_o, occupancy_o, load_complete_strands_o} !== {1'b1, 3'd0, 26'h800, 4'd1, 16'h0})
            $display("FAIL rmid_restart: got v%b e%0d a%h occ%0d c%h expected v1 e0 a800 occ1 c0", l2req_valid_o, l2req_entry_o, l2req_addr_o, occupancy_o, load_complete_strands_o); else passes++;
        @(negedge clk); #1;
        checks++; if (load_complete_strands_o !== 16'h0) $display("FAIL rmid_no_stale_wake: got %h expected 0", load_complete_strands_o); else passes++;
        l2rsp_valid_i = 1; l2rsp_entry_i = 0;
        @(negedge clk); l2rsp_valid_i = 0; #1;
        checks++; if ({load_complete_strands_o, occupancy_o} !== {16'h0008, 4'd0}) $display("FAIL rmid_wake: got c%h occ%0d expected c0008 occ0", load_complete_strands_o, occupancy_o); else passes++;
    endtask

    task automatic test_random();
        bit mv[8], ms[8], mi[8];
        logic [25:0] ma[8];
        logic [1:0] mw[8];
        logic [15:0] mm[8];
        logic [15:0] busy = 0, exp_c = 0;
        int exp_occ = 0, cand[$], fs[$];
        bit pv = 0, pr = 0, ps = 0, exp_v, coll, exp_acc;
        logic [2:0] pe = 0;
        logic [25:0] pa = 0;
        logic [1:0] pw = 0;
        int mg, fi, e, re;
        for (int i = 0; i < 8; i++) begin mv[i] = 0; ms[i] = 0; mi[i] = 0; ma[i] = 0; mw[i] = 0; mm[i] = 0; end
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            checks++; if (load_complete_strands_o !== exp_c) $display("FAIL rnd_complete@%0d: got %h expected %h", c, load_complete_strands_o, exp_c); else passes++;
            checks++; if (occupancy_o !== 4'(exp_occ)) $display("FAIL rnd_occ@%0d: got %0d expected %0d", c, occupancy_o, exp_occ); else passes++;
            l2req_ready_i = 1'($urandom_range(0, 1));
            l2rsp_valid_i = 0;
            cand.delete();
            for (int i = 0; i < 8; i++) if (mv[i] && mi[i]) cand.push_back(i);
            if (cand.size() > 0 && $urandom_range(0, 2) == 0) begin
                l2rsp_valid_i = 1;
                l2rsp_entry_i = 3'(cand[$urandom_range(0, cand.size() - 1)]);
            end
            request_i = 0;
            fs.delete();
            for (int s = 0; s < 16; s++) if (!busy[s]) fs.push_back(s);
            if (fs.size() > 0 && $urandom_range(0, 1) == 1)
                drive(fs[$urandom_range(0, fs.size() - 1)], 26'h40 + 26'($urandom_range(0, 5)),
                      1'($urandom_range(0, 3) == 0), 2'($urandom_range(0, 3)));
            #1;
            re = l2rsp_entry_i;
            coll = request_i && l2rsp_valid_i && ma[re] == request_addr;
            mg = -1; fi = -1;
            for (int i = 0; i < 8; i++) begin
                if (mg < 0 && mv[i] && !ms[i] && !synchronized_i && ma[i] == request_addr) mg = i;
                if (fi < 0 && !mv[i]) fi = i;
            end
            exp_acc = request_i && !coll && (mg >= 0 || fi >= 0);
            checks++; if (accept_o !== exp_acc) $display("FAIL rnd_accept@%0d: got %b expected %b", c, accept_o, exp_acc); else passes++;
            checks++; if (collision_o !== coll) $display("FAIL rnd_collision@%0d: got %b expected %b", c, collision_o, coll); else passes++;
            exp_v = 0;
            for (int i = 0; i < 8; i++) if (mv[i] && !mi[i]) exp_v = 1;
            checks++; if (l2req_valid_o !== exp_v) $display("FAIL rnd_valid@%0d: got %b expected %b", c, l2req_valid_o, exp_v); else passes++;
            if (l2req_valid_o === 1'b1) begin
                e = l2req_entry_o;
                checks++; if ({mv[e] && !mi[e], l2req_addr_o, l2req_way_o, l2req_sync_o} !== {1'b1, ma[e], mw[e], ms[e]})
                    $display("FAIL rnd_payload@%0d: entry %0d got a%h w%0d s%b expected pending a%h w%0d s%b", c, e, l2req_addr_o, l2req_way_o, l2req_sync_o, ma[e], mw[e], ms[e]); else passes++;
                if (pv && !pr) begin
                    checks++; if ({l2req_entry_o, l2req_addr_o, l2req_way_o, l2req_sync_o} !== {pe, pa, pw, ps})
                        $display("FAIL rnd_stable@%0d: got e%0d a%h expected e%0d a%h", c, l2req_entry_o, l2req_addr_o, pe, pa); else passes++;
                end
            end
            pv = l2req_valid_o; pr = l2req_ready_i; pe = l2req_entry_o; pa = l2req_addr_o; pw = l2req_way_o; ps = l2req_sync_o;
            exp_c = 0;
            if (l2rsp_valid_i) begin exp_c = mm[re]; busy &= ~mm[re]; mv[re] = 0; mm[re] = 0; end
            if (l2req_valid_o && l2req_ready_i) mi[l2req_entry_o] = 1;
            if (exp_acc) begin
                busy[strand_i] = 1;
                if (mg >= 0) mm[mg] |= 16'd1 << strand_i;
                else begin
                    mv[fi] = 1; mi[fi] = 0; ma[fi] = request_addr; mw[fi] = victim_way_i;
                    ms[fi] = synchronized_i; mm[fi] = 16'd1 << strand_i;
                end
            end
            exp_occ = 0;
            for (int i = 0; i < 8; i++) exp_occ += int'(mv[i]);
        end
        @(negedge clk); request_i = 0; l2rsp_valid_i = 0;
    endtask

    initial begin
        test_reset();
        test_single();
        test_merge();
        test_sync();
        test_full_stall();
        test_collision();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
